// File: rtl/mem_bist.sv
// March C- self-test engine for a single-port, byte-writable RAM with 1-cycle read latency.
// Runs the word march elements, then an optional byte-lane phase, and stops on the first mismatch.
module mem_bist #(
  parameter int          AW    = 8,
  parameter int          WSIZE = 4,
  parameter logic [7:0]  BG    = 8'h55,
  parameter logic [7:0]  BP    = 8'hA5,
  localparam int         DW    = 8 * WSIZE
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             start,
  input  logic             mode,
  output logic             busy,
  output logic             done,
  output logic             fail,
  output logic [AW-1:0]    fail_addr,
  output logic [DW-1:0]    fail_data,
  output logic             EN,
  output logic [WSIZE-1:0] WE,
  output logic [AW-1:0]    A,
  output logic [DW-1:0]    Di,
  input  logic [DW-1:0]    Do,
  output logic [3:0]       o_dbg_state
);

  localparam int              LW     = $clog2(WSIZE);
  localparam logic [DW-1:0]   P      = {WSIZE{BG}};
  localparam logic [AW-1:0]   A_LAST = {AW{1'b1}};

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_W0_UP   = 4'd1,
    S_R0W1_UP = 4'd2,
    S_R1W0_UP = 4'd3,
    S_R0W1_DN = 4'd4,
    S_R1W0_DN = 4'd5,
    S_R0_DN   = 4'd6,
    S_BYTE    = 4'd7,
    S_DRAIN   = 4'd8,
    S_DONE    = 4'd9
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [AW-1:0]     r_addr;
  logic              r_phase;
  logic              r_mode;
  logic              r_cmp_valid;
  logic [AW-1:0]     r_cmp_addr;
  logic [DW-1:0]     r_cmp_exp;
  logic              r_fail;
  logic [AW-1:0]     r_fail_addr;
  logic [DW-1:0]     r_fail_data;

  logic              w_busy;
  logic              w_accept;
  logic              w_mismatch;
  logic              w_dn;
  logic              w_next_dn;
  logic              w_two_cycle;
  logic              w_last_addr;
  logic              w_elem_end;
  logic              w_rd;
  logic [DW-1:0]     w_exp;
  logic              w_en;
  logic [WSIZE-1:0]  w_we;
  logic [AW-1:0]     w_a;
  logic [DW-1:0]     w_di;
  logic [LW+2:0]     w_lane_sh;
  logic [WSIZE-1:0]  w_lane_we;
  logic [DW-1:0]     w_lane_di;
  logic [DW-1:0]     w_lane_exp;

  // start is a single-cycle strobe, accepted only while busy=0; busy then rises on the
  // next cycle and stays high until the run ends, when done rises and holds with fail valid.
  assign w_busy     = (r_state != S_IDLE) && (r_state != S_DONE);
  assign w_accept   = start && !w_busy;
  assign w_mismatch = r_cmp_valid && (Do != r_cmp_exp);

  assign w_dn = (r_state == S_R0W1_DN) || (r_state == S_R1W0_DN) || (r_state == S_R0_DN);
  assign w_next_dn = (w_state_next == S_R0W1_DN) || (w_state_next == S_R1W0_DN) ||
                     (w_state_next == S_R0_DN);
  assign w_two_cycle = (r_state == S_R0W1_UP) || (r_state == S_R1W0_UP) ||
                       (r_state == S_R0W1_DN) || (r_state == S_R1W0_DN) ||
                       (r_state == S_BYTE);
  assign w_last_addr = w_dn ? (r_addr == '0) : (r_addr == A_LAST);
  assign w_elem_end  = w_last_addr && (!w_two_cycle || r_phase);

  // Byte phase: lane = address mod WSIZE, only that lane is written with BP.
  assign w_lane_sh  = {r_addr[LW-1:0], 3'b000};
  assign w_lane_we  = WSIZE'(1) << r_addr[LW-1:0];
  assign w_lane_di  = DW'(BP) << w_lane_sh;
  assign w_lane_exp = (P & ~(DW'(8'hFF) << w_lane_sh)) | w_lane_di;

  // State register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; a mismatch aborts straight to DONE from any busy state.
  always_comb begin
    w_state_next = r_state;
    if (w_busy && w_mismatch) begin
      w_state_next = S_DONE;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: if (start) w_state_next = S_W0_UP;
        S_W0_UP:        if (w_elem_end) w_state_next = S_R0W1_UP;
        S_R0W1_UP:      if (w_elem_end) w_state_next = S_R1W0_UP;
        S_R1W0_UP:      if (w_elem_end) w_state_next = S_R0W1_DN;
        S_R0W1_DN:      if (w_elem_end) w_state_next = S_R1W0_DN;
        S_R1W0_DN:      if (w_elem_end) w_state_next = S_R0_DN;
        S_R0_DN:        if (w_elem_end) w_state_next = r_mode ? S_BYTE : S_DRAIN;
        S_BYTE:         if (w_elem_end) w_state_next = S_DRAIN;
        S_DRAIN:        w_state_next = S_DONE;
        default:        w_state_next = S_IDLE;
      endcase
    end
  end

  // Output logic: RAM access pattern and the expected value of any read issued this cycle.
  always_comb begin
    w_en  = 1'b0;
    w_we  = '0;
    w_a   = '0;
    w_di  = '0;
    w_rd  = 1'b0;
    w_exp = '0;
    case (r_state)
      S_W0_UP: begin
        w_en = 1'b1;
        w_we = '1;
        w_a  = r_addr;
        w_di = P;
      end
      S_R0W1_UP, S_R0W1_DN: begin
        w_en = 1'b1;
        w_a  = r_addr;
        if (!r_phase) begin
          w_rd  = 1'b1;
          w_exp = P;
        end else begin
          w_we = '1;
          w_di = ~P;
        end
      end
      S_R1W0_UP, S_R1W0_DN: begin
        w_en = 1'b1;
        w_a  = r_addr;
        if (!r_phase) begin
          w_rd  = 1'b1;
          w_exp = ~P;
        end else begin
          w_we = '1;
          w_di = P;
        end
      end
      S_R0_DN: begin
        w_en  = 1'b1;
        w_a   = r_addr;
        w_rd  = 1'b1;
        w_exp = P;
      end
      S_BYTE: begin
        w_en = 1'b1;
        w_a  = r_addr;
        if (!r_phase) begin
          w_we = w_lane_we;
          w_di = w_lane_di;
        end else begin
          w_rd  = 1'b1;
          w_exp = w_lane_exp;
        end
      end
      default: begin
        w_en = 1'b0;
      end
    endcase
  end

  // Address sequencing, compare pipeline and result capture.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_addr      <= '0;
      r_phase     <= 1'b0;
      r_mode      <= 1'b0;
      r_cmp_valid <= 1'b0;
      r_cmp_addr  <= '0;
      r_cmp_exp   <= '0;
      r_fail      <= 1'b0;
      r_fail_addr <= '0;
      r_fail_data <= '0;
    end else begin
      // A read issued on the aborting edge is discarded along with the run.
      r_cmp_valid <= w_rd && !w_mismatch;
      r_cmp_addr  <= w_a;
      r_cmp_exp   <= w_exp;

      if (w_accept) begin
        r_mode      <= mode;
        r_fail      <= 1'b0;
        r_fail_addr <= '0;
        r_fail_data <= '0;
      end else if (w_busy && w_mismatch) begin
        r_fail      <= 1'b1;
        r_fail_addr <= r_cmp_addr;
        r_fail_data <= Do;
      end

      if (w_state_next != r_state) begin
        r_phase <= 1'b0;
        r_addr  <= w_next_dn ? A_LAST : '0;
      end else if (w_busy) begin
        if (w_two_cycle) r_phase <= ~r_phase;
        if (!w_two_cycle || r_phase) r_addr <= w_dn ? (r_addr - AW'(1)) : (r_addr + AW'(1));
      end
    end
  end

  assign busy        = w_busy;
  assign done        = (r_state == S_DONE);
  assign fail        = r_fail;
  assign fail_addr   = r_fail_addr;
  assign fail_data   = r_fail_data;
  assign EN          = w_en;
  assign WE          = w_we;
  assign A           = w_a;
  assign Di          = w_di;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mem_bist.sv
// Directed bench for mem_bist: behavioural byte-writable RAM with injectable faults,
// run-length and result checks for pass runs, stuck-bit and byte-lane faults, reset and restart.
module tb_mem_bist;

  localparam int AW = 8;
  localparam int WS = 4;
  localparam int DW = 32;

  logic          clk;
  logic          RST_N;
  logic          start;
  logic          mode;
  logic          busy;
  logic          done;
  logic          fail;
  logic [AW-1:0] fail_addr;
  logic [DW-1:0] fail_data;
  logic          EN;
  logic [WS-1:0] WE;
  logic [AW-1:0] A;
  logic [DW-1:0] Di;
  logic [DW-1:0] Do;
  logic [3:0]    dbg_state;

  mem_bist #(.AW(AW), .WSIZE(WS), .BG(8'h55), .BP(8'hA5)) dut (
    .CLK(clk), .RST_N(RST_N), .start(start), .mode(mode),
    .busy(busy), .done(done), .fail(fail), .fail_addr(fail_addr), .fail_data(fail_data),
    .EN(EN), .WE(WE), .A(A), .Di(Di), .Do(Do), .o_dbg_state(dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural RAM with fault injection
  logic [DW-1:0] mem [256];
  logic [DW-1:0] ram_wr;
  logic          flt_sa;
  logic          flt_we;
  logic          acc_clr;
  int            acc_cnt;

  always @(posedge clk) begin
    if (EN) begin
      Do <= mem[A];
      ram_wr = mem[A];
      for (int b = 0; b < WS; b++) begin
        if (WE[b] && !(flt_we && A == 8'h12 && b == 2 && WE != 4'hF))
          ram_wr[8*b +: 8] = Di[8*b +: 8];
      end
      if (flt_sa && A == 8'h21) ram_wr[9] = 1'b0;
      mem[A] <= ram_wr;
    end
  end

  always @(posedge clk) begin
    if (acc_clr) acc_cnt <= 0;
    else if (EN) acc_cnt <= acc_cnt + 1;
  end

  // Scoreboard counters
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_busy"},  64'(busy),      64'(0));
    check({tag, "_done"},  64'(done),      64'(0));
    check({tag, "_fail"},  64'(fail),      64'(0));
    check({tag, "_faddr"}, 64'(fail_addr), 64'(0));
    check({tag, "_fdata"}, 64'(fail_data), 64'(0));
    check({tag, "_en_we"}, 64'({EN, WE}),  64'(0));
    check({tag, "_a_di"},  64'({A, Di}),   64'(0));
  endtask

  // Driver: pulse start, then count busy cycles (bounded). Optionally re-pulse start
  // at cycle 'poke' or assert reset at cycle 'rst_at'.
  logic first_busy, first_done, first_fail;

  task automatic run(input logic m, input int poke, input int rst_at, output int len);
    @(negedge clk);
    start   = 1'b1;
    mode    = m;
    acc_clr = 1'b1;
    @(negedge clk);
    start      = 1'b0;
    acc_clr    = 1'b0;
    mode       = 1'b0;
    first_busy = busy;
    first_done = done;
    first_fail = fail;
    len = 0;
    while (busy && len < 20000) begin
      len++;
      if (len == rst_at) begin
        RST_N = 1'b0;
        #1;
        break;
      end
      start = (len == poke);
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  int len;
  int bad;

  initial begin
    RST_N   = 1'b0;
    start   = 1'b0;
    mode    = 1'b0;
    flt_sa  = 1'b0;
    flt_we  = 1'b0;
    acc_clr = 1'b0;
    Do      = '0;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    check("reset_state", 64'(dbg_state), 64'(0));
    RST_N = 1'b1;
    repeat (2) @(negedge clk);

    // Fault-free, word elements only
    run(1'b0, 0, 0, len);
    check("m0_len", 64'(len), 64'(2561));
    check("m0_done", 64'(done), 64'(1));
    check("m0_fail", 64'(fail), 64'(0));
    check("m0_state", 64'(dbg_state), 64'(9));
    repeat (4) @(negedge clk);
    check("m0_acc", 64'(acc_cnt), 64'(2560));
    bad = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== 32'h55555555) bad++;
    check("m0_mem_all_p", 64'(bad), 64'(0));

    // Fault-free with byte-lane phase
    run(1'b1, 0, 0, len);
    check("m1_len", 64'(len), 64'(3073));
    check("m1_done", 64'(done), 64'(1));
    check("m1_fail", 64'(fail), 64'(0));
    check("m1_mem6", 64'(mem[6]), 64'(32'h55A55555));
    check("m1_mem4", 64'(mem[4]), 64'(32'h555555A5));
    check("m1_mem255", 64'(mem[255]), 64'(32'hA5555555));

    // Bit 9 of word 0x21 stuck at 0: caught on the R1W0_UP read of ~P
    flt_sa = 1'b1;
    run(1'b0, 0, 0, len);
    check("sa_len", 64'(len), 64'(836));
    check("sa_done", 64'(done), 64'(1));
    check("sa_fail", 64'(fail), 64'(1));
    check("sa_faddr", 64'(fail_addr), 64'(8'h21));
    check("sa_fdata", 64'(fail_data), 64'(32'hAAAAA8AA));
    repeat (10) @(negedge clk);
    check("sa_acc", 64'(acc_cnt), 64'(836));
    check("sa_en_idle", 64'({EN, WE}), 64'(0));
    flt_sa = 1'b0;

    // Restart after a failing run clears done/fail at once; a start at cycle 100 is ignored
    run(1'b0, 100, 0, len);
    check("rs_busy1", 64'(first_busy), 64'(1));
    check("rs_done_clr", 64'(first_done), 64'(0));
    check("rs_fail_clr", 64'(first_fail), 64'(0));
    check("rs_len", 64'(len), 64'(2561));
    check("rs_fail", 64'(fail), 64'(0));

    // WE[2] ignored on partial writes to word 0x12: only the byte phase can see it
    flt_we = 1'b1;
    run(1'b1, 0, 0, len);
    check("bf_len", 64'(len), 64'(2599));
    check("bf_fail", 64'(fail), 64'(1));
    check("bf_faddr", 64'(fail_addr), 64'(8'h12));
    check("bf_fdata", 64'(fail_data), 64'(32'h55555555));
    repeat (4) @(negedge clk);
    check("bf_acc", 64'(acc_cnt), 64'(2599));
    flt_we = 1'b0;

    // Reset asserted mid-run aborts everything immediately
    run(1'b0, 0, 700, len);
    check("rst_at", 64'(len), 64'(700));
    check_outputs_zero("midrst");
    @(negedge clk);
    RST_N = 1'b1;
    repeat (2) @(negedge clk);
    check("post_rst_state", 64'(dbg_state), 64'(0));
    run(1'b0, 0, 0, len);
    check("post_rst_len", 64'(len), 64'(2561));
    check("post_rst_done", 64'(done), 64'(1));
    check("post_rst_fail", 64'(fail), 64'(0));

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
